// File: rtl/prefix_orient_ctrl.sv
// rtl/prefix_orient_ctrl.sv - read prefix classifier and payload orienter with error statistics
// Optional PREFIX_REVCOMP_EN: complement each symbol moved during reversal (reverse-complement).
module prefix_orient_ctrl #(
   parameter int N  = 100,
   parameter int P  = 4,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*N-1:0]       in_word,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*(N-2)-1:0]   out_word,
   output logic                 out_reversed,
   output logic                 out_in_prefix,
   output logic                 busy,
   input  logic                 cnt_clr,
   output logic [CW-1:0]        cnt_reversed,
   output logic [CW-1:0]        cnt_prefix_err
);

   localparam int M  = N - 2;
   localparam int IW = $clog2(M + P) + 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CLASSIFY = 2'd1;
   localparam logic [1:0] S_REVERSE  = 2'd2;
   localparam logic [1:0] S_OUT      = 2'd3;

`ifdef PREFIX_REVCOMP_EN
   localparam logic [1:0] SYM_XOR = 2'b11;
`else
   localparam logic [1:0] SYM_XOR = 2'b00;
`endif

   logic [1:0]       state;
   logic [2*N-1:0]   word_q;
   logic [2*M-1:0]   src_q;
   logic [2*M-1:0]   dst_q;
   logic [IW-1:0]    idx;
   logic             rev_q;
   logic             pfx_q;
   logic [CW-1:0]    cnt_rev_q;
   logic [CW-1:0]    cnt_pfx_q;

   logic [3:0]       top4;
   logic             cls_rev;
   logic             cls_pfx;
   logic [2*M-1:0]   cls_pay;
   logic [2*M-1:0]   rev_next;
   int               idx_i;
   logic             last_step;
   logic             out_hs;

   assign top4      = word_q[2*N-1 -: 4];
   assign idx_i     = int'(idx);
   assign last_step = (idx_i + P >= M);
   assign out_hs    = (state == S_OUT) && out_ready;

   // A deleted prefix symbol shifts the payload up by one symbol.
   always_comb begin
      cls_rev = 1'b0;
      cls_pfx = 1'b0;
      cls_pay = word_q[2*M-1:0];
      if (top4 == 4'b0100) begin
         cls_rev = 1'b0;
      end else if (top4[3:2] == 2'b01 || top4[3:2] == 2'b00) begin
         cls_pfx = 1'b1;
         cls_pay = word_q[2*(N-1)-1:2];
      end else if (top4 == 4'b1011) begin
         cls_rev = 1'b1;
      end else begin
         cls_rev = 1'b1;
         cls_pfx = 1'b1;
         cls_pay = word_q[2*(N-1)-1:2];
      end
   end

   always_comb begin
      rev_next = dst_q;
      for (int d = 0; d < M; d++) begin
         if ((M - 1 - d) >= idx_i && (M - 1 - d) < idx_i + P)
            rev_next[2*d +: 2] = src_q[2*(M-1-d) +: 2] ^ SYM_XOR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         word_q <= '0;
         src_q  <= '0;
         dst_q  <= '0;
         idx    <= '0;
         rev_q  <= 1'b0;
         pfx_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  word_q <= in_word;
                  state  <= S_CLASSIFY;
               end
            end
            S_CLASSIFY: begin
               rev_q <= cls_rev;
               pfx_q <= cls_pfx;
               idx   <= '0;
               if (cls_rev) begin
                  src_q <= cls_pay;
                  state <= S_REVERSE;
               end else begin
                  dst_q <= cls_pay;
                  state <= S_OUT;
               end
            end
            S_REVERSE: begin
               dst_q <= rev_next;
               idx   <= idx + IW'(P);
               if (last_step)
                  state <= S_OUT;
            end
            default: begin
               if (out_ready)
                  state <= S_IDLE;
            end
         endcase
      end
   end

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_rev_q <= '0;
         cnt_pfx_q <= '0;
      end else if (cnt_clr) begin
         cnt_rev_q <= '0;
         cnt_pfx_q <= '0;
      end else if (out_hs) begin
         if (rev_q && cnt_rev_q != '1)
            cnt_rev_q <= cnt_rev_q + CW'(1);
         if (pfx_q && cnt_pfx_q != '1)
            cnt_pfx_q <= cnt_pfx_q + CW'(1);
      end
   end

   assign in_ready       = (state == S_IDLE);
   assign busy           = (state != S_IDLE);
   assign out_valid      = (state == S_OUT);
   assign out_word       = dst_q;
   assign out_reversed   = rev_q;
   assign out_in_prefix  = pfx_q;
   assign cnt_reversed   = cnt_rev_q;
   assign cnt_prefix_err = cnt_pfx_q;

endmodule

// File: tb/tb_prefix_orient_ctrl.sv
// tb/tb_prefix_orient_ctrl.sv - directed and randomized checks of prefix_orient_ctrl against a symbol-level model
module tb_prefix_orient_ctrl;

   localparam int N   = 6;
   localparam int P   = 2;
   localparam int CW  = 2;
   localparam int M   = N - 2;
   localparam int SAT = (1 << CW) - 1;
   localparam int REV_LAT = 2 + (M + P - 1) / P;

`ifdef PREFIX_REVCOMP_EN
   localparam logic [1:0] RC = 2'b11;
`else
   localparam logic [1:0] RC = 2'b00;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2*N-1:0]  in_word;
   logic            out_valid;
   logic            out_ready;
   logic [2*M-1:0]  out_word;
   logic            out_reversed;
   logic            out_in_prefix;
   logic            busy;
   logic            cnt_clr;
   logic [CW-1:0]   cnt_reversed;
   logic [CW-1:0]   cnt_prefix_err;

   int checks = 0;
   int errors = 0;
   int mc_rev = 0;
   int mc_pfx = 0;

   prefix_orient_ctrl #(.N(N), .P(P), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_reversed(out_reversed), .out_in_prefix(out_in_prefix),
      .busy(busy), .cnt_clr(cnt_clr),
      .cnt_reversed(cnt_reversed), .cnt_prefix_err(cnt_prefix_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Symbol-level reading of the prefix rules.
   function automatic void model(input logic [2*N-1:0] w, output logic [2*M-1:0] o,
                                 output logic r, output logic p);
      logic [1:0] s [N];
      logic [1:0] pay [M];
      for (int i = 0; i < N; i++) s[i] = w[2*i +: 2];
      if (s[N-1] == 2'b01 && s[N-2] == 2'b00) begin
         r = 1'b0; p = 1'b0;
      end else if (s[N-1] == 2'b00 || s[N-1] == 2'b01) begin
         r = 1'b0; p = 1'b1;
      end else if (s[N-1] == 2'b10 && s[N-2] == 2'b11) begin
         r = 1'b1; p = 1'b0;
      end else begin
         r = 1'b1; p = 1'b1;
      end
      for (int i = 0; i < M; i++) pay[i] = p ? s[i+1] : s[i];
      for (int i = 0; i < M; i++) o[2*i +: 2] = r ? (pay[M-1-i] ^ RC) : pay[i];
   endfunction

   task automatic run_word(input logic [2*N-1:0] w, input logic [2*M-1:0] exp_o,
                           input int hold, input logic clr);
      logic [2*M-1:0] mo;
      logic er, ep;
      int lat, guard;
      model(w, mo, er, ep);
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
      check("in_ready_idle", 32'(in_ready), 32'(1));
      in_word  = w;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      check("in_ready_busy", 32'(in_ready), 32'(0));
      check("busy_set", 32'(busy), 32'(1));
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      check("latency", 32'(lat), er ? 32'(REV_LAT) : 32'(2));
      check("out_word", 32'(out_word), 32'(exp_o));
      check("out_reversed", 32'(out_reversed), 32'(er));
      check("out_in_prefix", 32'(out_in_prefix), 32'(ep));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_word  = ~w;
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'(1));
         check("hold_word", 32'(out_word), 32'(exp_o));
         check("hold_flags", 32'({out_reversed, out_in_prefix}), 32'({er, ep}));
         check("hold_in_ready", 32'(in_ready), 32'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = clr;
      @(posedge clk);
      if (clr) begin
         mc_rev = 0; mc_pfx = 0;
      end else begin
         if (er && mc_rev < SAT) mc_rev++;
         if (ep && mc_pfx < SAT) mc_pfx++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      cnt_clr   = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'(0));
      check("post_hs_in_ready", 32'(in_ready), 32'(1));
      check("cnt_reversed", 32'(cnt_reversed), 32'(mc_rev));
      check("cnt_prefix_err", 32'(cnt_prefix_err), 32'(mc_pfx));
   endtask

   initial begin
      logic [2*N-1:0] w;
      logic [2*M-1:0] mo;
      logic er, ep;
      int acc, outs, overlap, spur;

      rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; cnt_clr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_outputs", 32'({out_valid, out_reversed, out_in_prefix, busy}), 32'(0));
      check("rst_out_word", 32'(out_word), 32'(0));
      check("rst_counters", 32'({cnt_reversed, cnt_prefix_err}), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      run_word(12'b0100_00011011, 8'b00011011, 0, 1'b0);
`ifdef PREFIX_REVCOMP_EN
      run_word(12'b1011_00011011, 8'b00011011, 0, 1'b0);
      run_word(12'b11_00_01_10_11_01, 8'b00011011, 0, 1'b0);
`else
      run_word(12'b1011_00011011, 8'b11100100, 0, 1'b0);
      run_word(12'b11_00_01_10_11_01, 8'b11100100, 0, 1'b0);
`endif
      run_word(12'b01_01_10_11_00_10, 8'b01101100, 5, 1'b0);

      // Forward throughput with out_ready held high
      in_word = 12'b0100_11100001; in_valid = 1'b1; out_ready = 1'b1;
      acc = 0; outs = 0; overlap = 0;
      for (int i = 0; i < 12; i++) begin
         if (in_ready) acc++;
         if (out_valid) outs++;
         if (in_ready && out_valid) overlap++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("tput_accepts", 32'(acc), 32'(4));
      check("tput_outputs", 32'(outs), 32'(4));
      check("tput_overlap", 32'(overlap), 32'(0));
      @(negedge clk);
      out_ready = 1'b0;
      check("tput_idle", 32'(in_ready), 32'(1));

      // Abort a reversed word mid-flight
      in_word = 12'b1011_01101100; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      #1;
      check("abort_outputs", 32'({out_valid, out_reversed, out_in_prefix, busy}), 32'(0));
      check("abort_out_word", 32'(out_word), 32'(0));
      check("abort_counters", 32'({cnt_reversed, cnt_prefix_err}), 32'(0));
      mc_rev = 0; mc_pfx = 0;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      spur = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || busy) spur++;
      end
      out_ready = 1'b0;
      check("abort_no_output", 32'(spur), 32'(0));
      check("abort_in_ready", 32'(in_ready), 32'(1));

      // Saturation of the reversal counter
      for (int k = 0; k < 5; k++) begin
         w = {4'b1011, 8'($urandom)};
         model(w, mo, er, ep);
         run_word(w, mo, 0, 1'b0);
      end
      check("sat_cnt_reversed", 32'(cnt_reversed), 32'(3));
      w = 12'b11_00_01_10_11_01;
      model(w, mo, er, ep);
      run_word(w, mo, 1, 1'b1);
      check("clr_cnt_reversed", 32'(cnt_reversed), 32'(0));

      for (int k = 0; k < 40; k++) begin
         w = 12'($urandom);
         model(w, mo, er, ep);
         run_word(w, mo, int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prefix_orient_ctrl.md
Name: prefix_orient_ctrl

Overview:
- Sequencer for read-word prefix handling in the DNA decode path.
- Accepts one raw N-symbol read per valid/ready handshake and classifies its orientation and prefix-corruption status.
- Strips the prefix, serially reverses the payload symbol order when the read is backward, and presents an oriented (N-2)-symbol payload downstream with valid/ready.
- Maintains error/reversal statistics counters.

Parameters:
- N, 100, symbols per input read; 2 bits per symbol; N >= 4.
- P, 4, symbols moved per cycle during reversal; 1 <= P <= N-2.
- CW, 16, statistics counter width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  input word valid
- in_ready  output  1  controller can accept a word
- in_word  input  2*N  raw read; symbol N-1 at bits [2N-1:2N-2]
- out_valid  output  1  oriented payload valid
- out_ready  input  1  downstream accepts payload
- out_word  output  2*(N-2)  oriented payload; M = N-2 symbols
- out_reversed  output  1  read was backward and has been reversed
- out_in_prefix  output  1  prefix was corrupted (single-symbol prefix deletion)
- busy  output  1  FSM not in IDLE
- cnt_clr  input  1  synchronous clear of both counters
- cnt_reversed  output  CW  saturating count of reversed reads delivered
- cnt_prefix_err  output  CW  saturating count of corrupted-prefix reads delivered

Behaviour:
- Reset: FSM to IDLE. in_ready=1 after reset. out_valid=0, out_word=0, out_reversed=0, out_in_prefix=0, busy=0, both counters=0. Internal registers are cleared.
- Reset mid-operation: the word in flight is discarded. No output is produced for it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_word and go to CLASSIFY.
  - CLASSIFY: one cycle. Apply the prefix rules to the captured word and load the payload register. If rev=1, go to REVERSE with idx=0. Otherwise go to OUT.
  - REVERSE: each cycle, write payload symbols idx..idx+P-1 into destination positions M-1-idx..M-P-idx, clipped at M; then idx+=P. When idx+P >= M, go to OUT. Takes ceil(M/P) cycles.
  - OUT: out_valid=1. Data is stable until out_valid&&out_ready, then return to IDLE. Counters update on this handshake.
- Prefix rules, top symbols of the captured word, first match wins:
  - Top 4 bits == 4'b0100: rev=0, pfx=0, payload = bits [2(N-2)-1:0].
  - Top 2 bits == 01 or 00: rev=0, pfx=1, payload = bits [2(N-1)-1:2].
  - Top 4 bits == 4'b1011: rev=1, pfx=0, payload = bits [2(N-2)-1:0].
  - Otherwise: rev=1, pfx=1, payload = bits [2(N-1)-1:2].
- Reversal: output symbol i = payload symbol M-1-i. Symbol i occupies bits [2i+1:2i].
- Latency, with acceptance at edge T:
  - Forward read: out_valid high from T+2.
  - Reversed read: out_valid high from T+2+ceil(M/P).
  - Forward throughput: one word per 3 cycles when out_ready is held at 1.
- in_ready is 0 in every state except IDLE. Input is never accepted in the same cycle as an output handshake.
- Counters: on output handshake, cnt_reversed += out_reversed and cnt_prefix_err += out_in_prefix. Both saturate at 2^CW-1.
- cnt_clr: clears both counters. It takes priority over a same-cycle increment.

Optional Feature:
- Macro: PREFIX_REVCOMP_EN.
- Defined: during REVERSE, each moved symbol is complemented (XOR 2'b11), producing a reverse-complement. Forward reads are unaffected.
- Undefined: pure symbol-order reversal. Latency is identical in both cases.

Test Plan:
All scenarios use N=6, P=2 (M=4) unless noted.
- Clean forward: in_word=12'b0100_00011011 -> out_word=8'b00011011, out_reversed=0, out_in_prefix=0, out_valid at T+2.
- Clean reverse: in_word=12'b1011_00011011 -> out_word=8'b11100100, out_reversed=1, out_in_prefix=0, out_valid at T+4, cnt_reversed=1. With PREFIX_REVCOMP_EN: out_word=8'b00011011.
- Corrupt forward: in_word=12'b01_01_10_11_00_10 -> out_word=8'b01101100, out_reversed=0, out_in_prefix=1, cnt_prefix_err=1.
- Corrupt reverse: in_word=12'b11_00_01_10_11_01 -> out_word=8'b11100100, out_reversed=1, out_in_prefix=1, both counters increment.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_word and flags are stable, in_ready=0, a second in_valid is not accepted. Release -> handshake, then IDLE.
- Reset and saturation:
  - Assert rst during REVERSE -> all outputs 0 immediately, in_ready=1 after release, no output for the aborted word.
  - With CW=2, deliver 5 reversed reads -> cnt_reversed=3.
  - Pulse cnt_clr together with a handshake -> counter=0.
